mult_div_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the multicycle CPU datapath. It executes signed and unsigned multiply and divide on WIDTH-bit operands and holds the 2·WIDTH-bit result in internal HI/LO result registers. It replaces the separate fixed-width multiplier and divider with one shared shift/add–subtract engine. It adds unsigned modes, a busy/ready handshake and divide-by-zero detection. The control unit starts an operation and waits for `ready`, then writes `hi`/`lo` into the HI/LO registers.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 tb/tb_mult_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Shared multi-cycle multiply/divide engine: signed and unsigned MULT/DIV on WIDTH-bit
// operands, radix-2 shift-add multiply and restoring divide, with a busy/ready handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             ready,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz_pend;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept = (state == S_IDLE) && start && !dz_pend;
    assign busy   = (state != S_IDLE);

    // Operand magnitudes; op[0]=0 selects the signed variants.
    // NOTE: every variable driven here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, opnd};
        acc_next = {msum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (shifted >= {1'b0, opnd}) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            hi       <= '0;
            lo       <= '0;
            ready    <= 1'b0;
            div_zero <= 1'b0;
            dz_pend  <= 1'b0;
        end else begin
            ready    <= dz_pend;
            div_zero <= dz_pend;
            dz_pend  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op[1] && (b == '0)) begin
                            dz_pend <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (count == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers are always loaded on the accepting edge before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{WIDTH{1'b0}}, mag_a};
            opnd   <= mag_b;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            count  <= '0;
        end else if (state == S_CALC) begin
            acc   <= acc_next;
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32: result table, latency,
// back-to-back issue, divide-by-zero, ignored start and reset corner cases.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        ready;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .ready    (ready),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present an operation and pass the accepting edge E0; inputs are scrambled afterwards.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts edges after E0 (starting at first_k) until ready is seen; -1 on timeout.
    task automatic wait_ready(input int first_k, output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = first_k; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    vec_t vecs[12];
    int   lat;
    int   bcnt;
    int   rdy_cnt;

    initial begin
        vecs[0]  = '{"mult_neg3x7",     OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"multu_max",       OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"mult_m1xm1",      OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3]  = '{"div_neg7_2",      OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div_7_neg2",      OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5]  = '{"divu_big_2",      OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
        vecs[6]  = '{"div_min_m1",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[7]  = '{"div_neg7_neg2",   OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[8]  = '{"divu_100_7",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[9]  = '{"mult_min_x2",     OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{"multu_min_x2",    OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[11] = '{"multu_x10",       OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_div_zero", 64'(div_zero), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Each vector after the first is launched in the previous ready cycle (back-to-back).
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(1, lat, bcnt);
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd33);
            check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd32);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].lo));
            check({vecs[i].name, "_div_zero"}, 64'(div_zero), 64'h0);
        end

        // Divide by zero, issued in the ready cycle of the last table entry.
        launch(OP_DIVU, 32'd5, 32'd0);
        check("dz_e0_ready", 64'(ready), 64'h0);
        check("dz_e0_busy", 64'(busy), 64'h0);
        @(posedge clk);
        #1;
        check("dz_e1_ready", 64'(ready), 64'h1);
        check("dz_e1_flag", 64'(div_zero), 64'h1);
        check("dz_e1_busy", 64'(busy), 64'h0);
        check("dz_hi_held", 64'(hi), 64'h00000001);
        check("dz_lo_held", 64'(lo), 64'h23456780);
        @(posedge clk);
        #1;
        check("dz_e2_ready", 64'(ready), 64'h0);
        check("dz_e2_flag", 64'(div_zero), 64'h0);
        check("dz_e2_busy", 64'(busy), 64'h0);

        // A start pulse five cycles into a multiply must be ignored.
        launch(OP_MULT, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(7, lat, bcnt);
        check("ignored_start_latency", 64'(lat), 64'd33);
        check("ignored_start_hi", 64'(hi), 64'h0);
        check("ignored_start_lo", 64'(lo), 64'd15);

        // Reset ten cycles into a multiply aborts it without a ready pulse.
        launch(OP_MULT, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hi", 64'(hi), 64'h0);
        check("abort_lo", 64'(lo), 64'h0);
        check("abort_ready", 64'(ready), 64'h0);
        @(negedge clk);
        reset   = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (ready) rdy_cnt++;
        end
        check("abort_no_ready", 64'(rdy_cnt), 64'h0);

        // Reset and start together: reset wins and the unit stays idle.
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd3;
        @(posedge clk);
        #1;
        check("rst_start_busy", 64'(busy), 64'h0);
        @(negedge clk);
        reset   = 1'b0;
        start   = 1'b0;
        rdy_cnt = 0;
        bcnt    = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) rdy_cnt++;
            if (busy) bcnt++;
        end
        check("rst_start_no_busy", 64'(bcnt), 64'h0);
        check("rst_start_no_ready", 64'(rdy_cnt), 64'h0);
        check("rst_start_lo", 64'(lo), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
